// File: rtl/dct4.sv
`default_nettype none
// ============================================================================
// Module   : dct4
// Purpose  : Forward 4-point HEVC integer DCT. Collects four samples over a
//            valid/ready input, runs an even/odd butterfly then the 64/83/36
//            constant multiplies, and presents four coefficients in parallel
//            behind a valid/ready output. Optional rounding shift by SHIFT.
// Revision : 1.0 - initial release
// ============================================================================
module dct4 #(
  parameter int WIDTH_X = 16,
  parameter int WIDTH_Y = 24,
  parameter int SHIFT   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_X-1:0] x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_Y-1:0] y0,
  output logic signed [WIDTH_Y-1:0] y1,
  output logic signed [WIDTH_Y-1:0] y2,
  output logic signed [WIDTH_Y-1:0] y3
);

  localparam logic [1:0] c_COLLECT = 2'd0;
  localparam logic [1:0] c_BFLY    = 2'd1;
  localparam logic [1:0] c_MULT    = 2'd2;
  localparam logic [1:0] c_OUT     = 2'd3;

  // Butterfly width, exact product width, and rounding-sum width.
  localparam int c_WE  = WIDTH_X + 1;
  localparam int c_WP  = WIDTH_X + 8;
  localparam int c_WR  = WIDTH_X + 9;
  localparam int c_RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [c_WR-1:0] c_RND = c_WR'((SHIFT > 0) ? (1 << c_RSH) : 0);

  logic [1:0] state_q, state_d;
  logic [1:0] count_q;
  logic signed [WIDTH_X-1:0] slot_q [4];
  logic signed [c_WE-1:0] e0_q, e1_q, o0_q, o1_q;

  logic w_accept;
  logic signed [c_WP-1:0] w_e0, w_e1, w_o0, w_o1;
  logic signed [c_WP-1:0] w_y0, w_y1, w_y2, w_y3;

  // Round (when SHIFT>0), arithmetic shift, then fit to the output width.
  function automatic logic signed [WIDTH_Y-1:0] f_finish(input logic signed [c_WP-1:0] v);
    logic signed [c_WR-1:0] t;
    t = c_WR'(v) + c_RND;
    t = t >>> SHIFT;
    return WIDTH_Y'(t);
  endfunction

  assign w_accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_COLLECT;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed one-cycle BFLY and MULT, handshake-gated ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_COLLECT: if (w_accept && count_q == 2'd3) state_d = c_BFLY;
      c_BFLY:    state_d = c_MULT;
      c_MULT:    state_d = c_OUT;
      c_OUT:     if (out_valid && out_ready) state_d = c_COLLECT;
      default:   state_d = c_COLLECT;
    endcase
  end

  // Output logic: input side is open only while collecting.
  always_comb begin
    in_ready = (state_q == c_COLLECT);
  end

  // Exact constant multiplies as shift-add on sign-extended butterfly terms.
  always_comb begin
    w_e0 = c_WP'(e0_q);
    w_e1 = c_WP'(e1_q);
    w_o0 = c_WP'(o0_q);
    w_o1 = c_WP'(o1_q);
    w_y0 = (w_e0 + w_e1) <<< 6;
    w_y2 = (w_e0 - w_e1) <<< 6;
    w_y1 = (w_o0 <<< 6) + (w_o0 <<< 4) + (w_o0 <<< 1) + w_o0
         + (w_o1 <<< 5) + (w_o1 <<< 2);
    w_y3 = (w_o0 <<< 5) + (w_o0 <<< 2)
         - ((w_o1 <<< 6) + (w_o1 <<< 4) + (w_o1 <<< 1) + w_o1);
  end

  // Datapath: sample capture, butterfly, coefficient register and out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      e0_q      <= '0;
      e1_q      <= '0;
      o0_q      <= '0;
      o1_q      <= '0;
      y0        <= '0;
      y1        <= '0;
      y2        <= '0;
      y3        <= '0;
      out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        slot_q[count_q] <= x;
        count_q         <= count_q + 2'd1;
      end
      if (state_q == c_BFLY) begin
        e0_q <= c_WE'(slot_q[0]) + c_WE'(slot_q[3]);
        e1_q <= c_WE'(slot_q[1]) + c_WE'(slot_q[2]);
        o0_q <= c_WE'(slot_q[0]) - c_WE'(slot_q[3]);
        o1_q <= c_WE'(slot_q[1]) - c_WE'(slot_q[2]);
      end
      if (state_q == c_MULT) begin
        y0        <= f_finish(w_y0);
        y1        <= f_finish(w_y1);
        y2        <= f_finish(w_y2);
        y3        <= f_finish(w_y3);
        out_valid <= 1'b1;
      end else if (state_q == c_OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct4.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct4
// Purpose  : Directed bench for dct4: full-precision instance plus a
//            SHIFT=7 / WIDTH_Y=17 instance driven from the same inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct4;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic signed [15:0] x;
  logic in_ready, out_valid, in_ready_r, out_valid_r;
  logic signed [23:0] y0, y1, y2, y3;
  logic signed [16:0] r0, r1, r2, r3;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0][15:0] xs;
    logic [7:0]       gap;
    logic [3:0][23:0] ey;
    logic [3:0][16:0] er;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  dct4 #(.WIDTH_X(16), .WIDTH_Y(24), .SHIFT(0)) u_full (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3)
  );

  dct4 #(.WIDTH_X(16), .WIDTH_Y(17), .SHIFT(7)) u_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r), .x(x),
    .out_valid(out_valid_r), .out_ready(out_ready),
    .y0(r0), .y1(r1), .y2(r2), .y3(r3)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Feed four samples with optional idle gaps; report cycles from 4th accept to out_valid.
  task automatic send_block(input logic [3:0][15:0] xs, input int gap, output int lat);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      x = $signed(xs[i]);
      chk("in_ready_before_sample", longint'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic chk_full(input logic [3:0][23:0] e);
    chk("y0", longint'(y0), longint'($signed(e[0])));
    chk("y1", longint'(y1), longint'($signed(e[1])));
    chk("y2", longint'(y2), longint'($signed(e[2])));
    chk("y3", longint'(y3), longint'($signed(e[3])));
  endtask

  task automatic chk_rnd(input logic [3:0][16:0] e);
    chk("r0", longint'(r0), longint'($signed(e[0])));
    chk("r1", longint'(r1), longint'($signed(e[1])));
    chk("r2", longint'(r2), longint'($signed(e[2])));
    chk("r3", longint'(r3), longint'($signed(e[3])));
  endtask

  initial begin
    int lat;
    logic [3:0][15:0] b1234;
    logic [3:0][15:0] bdc;
    logic [3:0][23:0] e1234;

    // xs / ey / er are listed element 3 first (packed order).
    vecs[0] = '{xs: {16'sd4, 16'sd3, 16'sd2, 16'sd1}, gap: 8'd0,
                ey: {-24'sd25, 24'sd0, -24'sd285, 24'sd640},
                er: {17'sd0, 17'sd0, -17'sd2, 17'sd5}};
    vecs[1] = '{xs: {16'sd100, 16'sd100, 16'sd100, 16'sd100}, gap: 8'd0,
                ey: {24'sd0, 24'sd0, 24'sd0, 24'sd25600},
                er: {17'sd0, 17'sd0, 17'sd0, 17'sd200}};
    vecs[2] = '{xs: {-16'sd32768, -16'sd32768, 16'sd32767, 16'sd32767}, gap: 8'd0,
                ey: {-24'sd3080145, 24'sd0, 24'sd7798665, -24'sd128},
                er: {-17'sd24064, 17'sd0, 17'sd60927, -17'sd1}};
    vecs[3] = '{xs: {16'sd4, 16'sd3, 16'sd2, 16'sd1}, gap: 8'd2,
                ey: {-24'sd25, 24'sd0, -24'sd285, 24'sd640},
                er: {17'sd0, 17'sd0, -17'sd2, 17'sd5}};
    vecs[4] = '{xs: {-16'sd40, 16'sd30, -16'sd20, 16'sd10}, gap: 8'd1,
                ey: {24'sd5950, -24'sd2560, 24'sd2350, -24'sd1280},
                er: {17'sd46, -17'sd20, 17'sd18, -17'sd10}};
    b1234 = vecs[0].xs;
    bdc   = vecs[1].xs;
    e1234 = vecs[0].ey;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_y0", longint'(y0), 0);
    chk("reset_y3", longint'(y3), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", longint'(in_ready), 1);

    // Table-driven blocks with out_ready held high.
    for (int v = 0; v < 5; v++) begin
      send_block(vecs[v].xs, int'(vecs[v].gap), lat);
      chk("latency", longint'(lat), 2);
      chk("in_ready_low_in_out", longint'(in_ready), 0);
      chk("rnd_out_valid", longint'(out_valid_r), 1);
      chk_full(vecs[v].ey);
      chk_rnd(vecs[v].er);
      @(posedge clk); #1;
      chk("out_valid_cleared", longint'(out_valid), 0);
      chk("in_ready_back", longint'(in_ready), 1);
      chk_full(vecs[v].ey);
    end

    // Backpressure: hold out_ready low 5 cycles while pulsing in_valid.
    out_ready = 1'b0;
    send_block(b1234, 0, lat);
    chk("bp_latency", longint'(lat), 2);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      x = 16'sd999;
      @(posedge clk); #1;
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
      chk_full(e1234);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_released", longint'(out_valid), 0);
    chk("bp_in_ready_back", longint'(in_ready), 1);
    send_block(bdc, 0, lat);
    chk("post_bp_latency", longint'(lat), 2);
    chk_full(vecs[1].ey);
    @(posedge clk); #1;

    // Reset mid-block: two samples, then an asynchronous reset pulse between edges.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      x = 16'sd77;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_y0", longint'(y0), 0);
    chk("async_rst_out_valid", longint'(out_valid), 0);
    chk("async_rst_in_ready", longint'(in_ready), 1);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_block(b1234, 0, lat);
    chk("post_rst_latency", longint'(lat), 2);
    chk_full(e1234);
    chk_rnd(vecs[0].er);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so a stuck design still ends the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
